// File: rtl/ram_read_seq.sv
// Read-side sequencer: walks 3x3 valid-convolution windows over the stored image,
// fetches image/weight word pairs and streams them out through a 2-entry FIFO.
module ram_read_seq #(
    parameter int DATA_W  = 128,
    parameter int IMG_AW  = 10,
    parameter int WGT_AW  = 5,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              convStart,
    input  logic [5:0]        W,
    input  logic [5:0]        H,
    input  logic [4:0]        C,
    output logic              ramImage_en,
    output logic [IMG_AW-1:0] ramImage_addrR,
    input  logic [DATA_W-1:0] ramImage_dout,
    output logic              ramWeight_en,
    output logic [WGT_AW-1:0] ramWeight_addrR,
    input  logic [DATA_W-1:0] ramWeight_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic [DATA_W-1:0] wgt_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              win_first,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [5:0]        w_q, w_d;
    logic [5:0]        h_q, h_d;
    logic [4:0]        c_q, c_d;
    logic [4:0]        ox_q, ox_d;
    logic [4:0]        oy_q, oy_d;
    logic [1:0]        kx_q, kx_d;
    logic [1:0]        ky_q, ky_d;
    logic [IMG_AW-1:0] rowb_q, rowb_d;
    logic [IMG_AW-1:0] oyb_q, oyb_d;

    logic [RAM_LAT-1:0] pv_q;
    logic [RAM_LAT-1:0] pf_q;
    logic [RAM_LAT-1:0] pl_q;
    logic [1:0]         inflight_q, inflight_d;

    logic [DATA_W-1:0] fp_q [2];
    logic [DATA_W-1:0] fw_q [2];
    logic [1:0]        ff_q;
    logic [1:0]        fl_q;
    logic              rd_q;
    logic              wr_q;
    logic [1:0]        cnt_q, cnt_d;

    logic              dims_ok;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occ;
    logic              tap_first;
    logic              tap_last;
    logic              last_col;
    logic              last_row;
    logic              final_issue;
    logic              drain_end;
    logic [IMG_AW-1:0] img_addr;
    logic [3:0]        wgt_tap;
    logic [4:0]        eff_c;
    logic [DATA_W-1:0] lane_mask;

    assign dims_ok   = (w_q >= 6'd3) && (h_q >= 6'd3);
    assign win_valid = (cnt_q != 2'd0);
    assign pop       = win_valid && win_ready;
    assign push      = pv_q[RAM_LAT-1];
    assign occ       = 3'(cnt_q) + 3'(inflight_q);

    // A slot freed by this cycle's pop can be reused at once, giving 1 beat/cycle.
    assign issue = (state_q == S_RUN) && dims_ok &&
                   ((occ < 3'd2) || ((occ == 3'd2) && pop));

    assign tap_first   = (kx_q == 2'd0) && (ky_q == 2'd0);
    assign tap_last    = (kx_q == 2'd2) && (ky_q == 2'd2);
    assign last_col    = ({1'b0, ox_q} == (w_q - 6'd3));
    assign last_row    = ({1'b0, oy_q} == (h_q - 6'd3));
    assign final_issue = issue && tap_last && last_col && last_row;
    assign drain_end   = (inflight_q == 2'd0) && (cnt_q == 2'd1) && pop;

    assign img_addr = rowb_q + IMG_AW'(ox_q) + IMG_AW'(kx_q);
    assign wgt_tap  = 4'({ky_q, 1'b0}) + 4'(ky_q) + 4'(kx_q);

    assign ramImage_en     = issue;
    assign ramWeight_en    = issue;
    assign ramImage_addrR  = issue ? img_addr : '0;
    assign ramWeight_addrR = issue ? WGT_AW'(wgt_tap) : '0;

    assign inflight_d = inflight_q + 2'(issue) - 2'(push);
    assign cnt_d      = cnt_q + 2'(push) - 2'(pop);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        c_d     = c_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        rowb_d  = rowb_q;
        oyb_d   = oyb_q;
        unique case (state_q)
            S_IDLE: begin
                if (convStart) begin
                    state_d = S_RUN;
                    w_d     = (W > 6'd32) ? 6'd32 : W;
                    h_d     = (H > 6'd32) ? 6'd32 : H;
                    c_d     = C;
                    ox_d    = '0;
                    oy_d    = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    rowb_d  = '0;
                    oyb_d   = '0;
                end
            end
            S_RUN: begin
                if (!dims_ok) begin
                    state_d = S_DONE;
                end else if (final_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Row base tracks (oy+ky)*W as a running sum; oyb holds oy*W.
        if (issue && !final_issue) begin
            if (kx_q != 2'd2) begin
                kx_d = kx_q + 2'd1;
            end else begin
                kx_d = '0;
                if (ky_q != 2'd2) begin
                    ky_d   = ky_q + 2'd1;
                    rowb_d = rowb_q + IMG_AW'(w_q);
                end else begin
                    ky_d = '0;
                    if (!last_col) begin
                        ox_d   = ox_q + 5'd1;
                        rowb_d = oyb_q;
                    end else begin
                        ox_d   = '0;
                        oy_d   = oy_q + 5'd1;
                        oyb_d  = oyb_q + IMG_AW'(w_q);
                        rowb_d = oyb_q + IMG_AW'(w_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            c_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            rowb_q     <= '0;
            oyb_q      <= '0;
            pv_q       <= '0;
            pf_q       <= '0;
            pl_q       <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            c_q        <= c_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            rowb_q     <= rowb_d;
            oyb_q      <= oyb_d;
            inflight_q <= inflight_d;
            for (int i = RAM_LAT - 1; i > 0; i--) begin
                pv_q[i] <= pv_q[i-1];
                pf_q[i] <= pf_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
            pv_q[0] <= issue;
            pf_q[0] <= issue && tap_first;
            pl_q[0] <= issue && tap_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fp_q[0] <= '0;
            fp_q[1] <= '0;
            fw_q[0] <= '0;
            fw_q[1] <= '0;
            ff_q    <= '0;
            fl_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (push) begin
                fp_q[wr_q] <= ramImage_dout;
                fw_q[wr_q] <= ramWeight_dout;
                ff_q[wr_q] <= pf_q[RAM_LAT-1];
                fl_q[wr_q] <= pl_q[RAM_LAT-1];
            end
            wr_q  <= wr_q ^ push;
            rd_q  <= rd_q ^ pop;
            cnt_q <= cnt_d;
        end
    end

    assign eff_c = ((c_q == 5'd0) || (c_q > 5'd16)) ? 5'd16 : c_q;

    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l < int'(eff_c)) begin
                lane_mask[l*8 +: 8] = 8'hFF;
            end
        end
    end

    assign pix_data  = win_valid ? (fp_q[rd_q] & lane_mask) : '0;
    assign wgt_data  = win_valid ? (fw_q[rd_q] & lane_mask) : '0;
    assign win_first = win_valid && ff_q[rd_q];
    assign win_last  = win_valid && fl_q[rd_q];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_read_seq.sv
// Directed bench for ram_read_seq with a 1-cycle-latency RAM model.
module tb_ram_read_seq;

    localparam int DW  = 128;
    localparam int IAW = 10;
    localparam int WAW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           convStart;
    logic [5:0]     W;
    logic [5:0]     H;
    logic [4:0]     C;
    logic           ramImage_en;
    logic [IAW-1:0] ramImage_addrR;
    logic [DW-1:0]  ramImage_dout;
    logic           ramWeight_en;
    logic [WAW-1:0] ramWeight_addrR;
    logic [DW-1:0]  ramWeight_dout;
    logic [DW-1:0]  pix_data;
    logic [DW-1:0]  wgt_data;
    logic           win_valid;
    logic           win_ready;
    logic           win_first;
    logic           win_last;
    logic           busy;
    logic           done;

    ram_read_seq dut (
        .clk             (clk),
        .rst             (rst),
        .convStart       (convStart),
        .W               (W),
        .H               (H),
        .C               (C),
        .ramImage_en     (ramImage_en),
        .ramImage_addrR  (ramImage_addrR),
        .ramImage_dout   (ramImage_dout),
        .ramWeight_en    (ramWeight_en),
        .ramWeight_addrR (ramWeight_addrR),
        .ramWeight_dout  (ramWeight_dout),
        .pix_data        (pix_data),
        .wgt_data        (wgt_data),
        .win_valid       (win_valid),
        .win_ready       (win_ready),
        .win_first       (win_first),
        .win_last        (win_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] img_word(input int a);
        logic [DW-1:0] r;
        for (int l = 0; l < 16; l++) r[l*8 +: 8] = 8'(a * 7 + l * 29 + 1);
        return r;
    endfunction

    function automatic logic [DW-1:0] wgt_word(input int a);
        logic [DW-1:0] r;
        for (int l = 0; l < 16; l++) r[l*8 +: 8] = 8'(a * 11 + l * 5 + 128);
        return r;
    endfunction

    function automatic logic [DW-1:0] msk(input logic [DW-1:0] d, input int c);
        logic [DW-1:0] r;
        int e;
        r = d;
        e = (c == 0 || c > 16) ? 16 : c;
        for (int l = 0; l < 16; l++) if (l >= e) r[l*8 +: 8] = 8'h00;
        return r;
    endfunction

    function automatic int exp_iaddr(input int k, input int w);
        int tap, win, ox, oy;
        tap = k % 9;
        win = k / 9;
        ox  = win % (w - 2);
        oy  = win / (w - 2);
        return (oy + tap / 3) * w + ox + tap % 3;
    endfunction

    logic ones;

    always_ff @(posedge clk) begin
        if (ramImage_en)
            ramImage_dout <= ones ? '1 : img_word(int'(ramImage_addrR));
        if (ramWeight_en)
            ramWeight_dout <= ones ? '1 : wgt_word(int'(ramWeight_addrR));
    end

    int checks = 0;
    int errors = 0;

    `define CHK(tag, obs, exp) \
        begin \
            checks++; \
            assert ((obs) === (exp)) else begin \
                errors++; \
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
            end \
        end

    int            n_en, n_acc, n_first, n_last;
    int            bad_addr, bad_data, bad_hold, bad_credit, busy_bad;
    int            done_cnt, done_t, last_t;
    bit            timeout;
    int            iaddr_log [64];
    logic [DW-1:0] first_pix, first_wgt;

    task automatic run(input int w, input int h, input int c, input bit rnd,
                       input int extra_at, input int abort_at);
        logic [DW-1:0] hp, hw;
        logic          hf, hl;
        bit            hpend;
        int            ew;
        logic [DW-1:0] ep, eg;
        n_en = 0; n_acc = 0; n_first = 0; n_last = 0;
        bad_addr = 0; bad_data = 0; bad_hold = 0; bad_credit = 0; busy_bad = 0;
        done_cnt = 0; done_t = -1; last_t = -1; timeout = 1'b1; hpend = 1'b0;
        hp = '0; hw = '0; hf = 1'b0; hl = 1'b0;
        ew = (w > 32) ? 32 : w;
        for (int t = 0; t < 40000; t++) begin
            @(negedge clk);
            if (abort_at >= 0 && n_acc == abort_at) begin
                rst = 1'b1;
                timeout = 1'b0;
                break;
            end
            convStart = (t == 0) || (t == extra_at);
            W = (t == 0) ? 6'(w) : 6'd7;
            H = (t == 0) ? 6'(h) : 6'd9;
            C = 5'(c);
            win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (hpend && !(win_valid && pix_data == hp && wgt_data == hw &&
                           win_first == hf && win_last == hl))
                bad_hold++;
            if (t > 0 && !busy) busy_bad++;
            if (n_en - n_acc > 2) bad_credit++;
            if (ramImage_en) begin
                if (n_en < 64) iaddr_log[n_en] = int'(ramImage_addrR);
                if (int'(ramImage_addrR) != exp_iaddr(n_en, ew) ||
                    int'(ramWeight_addrR) != n_en % 9 || !ramWeight_en)
                    bad_addr++;
                n_en++;
            end else if (ramWeight_en) begin
                bad_addr++;
            end
            if (win_valid && win_ready) begin
                ep = msk(ones ? '1 : img_word(exp_iaddr(n_acc, ew)), c);
                eg = msk(ones ? '1 : wgt_word(n_acc % 9), c);
                if (n_acc == 0) begin
                    first_pix = pix_data;
                    first_wgt = wgt_data;
                end
                if (win_first) n_first++;
                if (win_last) n_last++;
                if (pix_data != ep || wgt_data != eg ||
                    win_first != (n_acc % 9 == 0) || win_last != (n_acc % 9 == 8))
                    bad_data++;
                n_acc++;
                last_t = t;
            end
            hpend = win_valid && !win_ready;
            hp = pix_data; hw = wgt_data; hf = win_first; hl = win_last;
            if (done) begin
                done_cnt++;
                done_t = t;
                timeout = 1'b0;
                break;
            end
        end
        convStart = 1'b0;
    endtask

    int e2 [9];
    int mis;

    initial begin
        rst = 1'b1; convStart = 1'b0; W = '0; H = '0; C = '0;
        win_ready = 1'b0; ones = 1'b0;
        first_pix = '0; first_wgt = '0;
        repeat (3) @(negedge clk);
        #1;
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_valid", win_valid, 1'b0)
        `CHK("rst_en", ramImage_en, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_pix", pix_data, 128'h0)
        rst = 1'b0;

        // 3x3 image: one window, full throughput
        run(3, 3, 16, 1'b0, -1, -1);
        `CHK("t1_timeout", timeout, 1'b0)
        `CHK("t1_beats", n_acc, 9)
        `CHK("t1_reads", n_en, 9)
        `CHK("t1_addr4", iaddr_log[4], 4)
        `CHK("t1_addr8", iaddr_log[8], 8)
        `CHK("t1_first", n_first, 1)
        `CHK("t1_last", n_last, 1)
        `CHK("t1_badaddr", bad_addr, 0)
        `CHK("t1_baddata", bad_data, 0)
        `CHK("t1_done_t", done_t, 12)
        `CHK("t1_done_lat", done_t, last_t + 1)
        `CHK("t1_busy", busy_bad, 0)
        @(negedge clk); #1;
        `CHK("t1_done_pulse", done, 1'b0)
        `CHK("t1_idle", busy, 1'b0)

        // 4x3 image, C=7 masking on live data
        run(4, 3, 7, 1'b0, -1, -1);
        e2 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        mis = 0;
        for (int i = 0; i < 9; i++) if (iaddr_log[9 + i] != e2[i]) mis++;
        `CHK("t2_beats", n_acc, 18)
        `CHK("t2_win2_addr", mis, 0)
        `CHK("t2_first", n_first, 2)
        `CHK("t2_baddata", bad_data, 0)
        `CHK("t2_done_t", done_t, 21)

        // 32x32 with random backpressure
        run(32, 32, 16, 1'b1, -1, -1);
        `CHK("t3_timeout", timeout, 1'b0)
        `CHK("t3_beats", n_acc, 8100)
        `CHK("t3_reads", n_en, 8100)
        `CHK("t3_first", n_first, 900)
        `CHK("t3_baddata", bad_data, 0)
        `CHK("t3_badaddr", bad_addr, 0)
        `CHK("t3_hold", bad_hold, 0)
        `CHK("t3_credit", bad_credit, 0)
        `CHK("t3_done_lat", done_t, last_t + 1)

        // lane masking with all-ones RAM contents
        ones = 1'b1;
        run(3, 3, 4, 1'b0, -1, -1);
        `CHK("t4_pix_c4", first_pix, {96'h0, 32'hFFFF_FFFF})
        `CHK("t4_wgt_c4", first_wgt, {96'h0, 32'hFFFF_FFFF})
        `CHK("t4_baddata_c4", bad_data, 0)
        run(3, 3, 0, 1'b0, -1, -1);
        `CHK("t4_pix_c0", first_pix, {128{1'b1}})
        `CHK("t4_wgt_c0", first_wgt, {128{1'b1}})
        ones = 1'b0;

        // degenerate width, then ignored restart
        run(2, 5, 16, 1'b0, -1, -1);
        `CHK("t5_no_reads", n_en, 0)
        `CHK("t5_no_beats", n_acc, 0)
        `CHK("t5_done_t", done_t, 2)
        run(3, 3, 16, 1'b0, 5, -1);
        `CHK("t5_restart_beats", n_acc, 9)
        `CHK("t5_restart_done_t", done_t, 12)
        `CHK("t5_restart_data", bad_data, 0)

        // reset mid-run, then a clean full run
        run(8, 8, 16, 1'b0, -1, 40);
        @(negedge clk); #1;
        `CHK("t6_busy", busy, 1'b0)
        `CHK("t6_valid", win_valid, 1'b0)
        `CHK("t6_en", ramImage_en, 1'b0)
        `CHK("t6_done", done, 1'b0)
        rst = 1'b0;
        mis = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (done || busy) mis++;
        end
        `CHK("t6_quiet", mis, 0)
        run(8, 8, 16, 1'b0, -1, -1);
        `CHK("t6_beats", n_acc, 324)
        `CHK("t6_baddata", bad_data, 0)
        `CHK("t6_badaddr", bad_addr, 0)
        `CHK("t6_done_lat", done_t, last_t + 1)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
